oa_write_engine: RTL and testbench
==================================

Name: oa_write_engine

Overview:
- ICB write master at the output-activation end of the MMA datapath.
- Accepts one requantised int8 output row of SIZE lanes at a time and packs it into BUS_WIDTH-bit words.
- Before touching the bus it requests write_oa_req and waits for write_oa_granted from the MMA controller, which owns icb_sel.
- Signals write_done after each row is fully acknowledged, and oa_calc_over after the last configured row.

Parameters:
SIZE, 16, lanes per output row (int8 each)
BUS_WIDTH, 32, ICB data width; SIZE*8 must be a multiple of BUS_WIDTH
REG_WIDTH, 32, address/config register width
WORDS (localparam), SIZE*8/BUS_WIDTH, bus words per row (4 at defaults)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
init_cfg_oa  in  1  single-cycle config pulse
cfg_oa_base_addr  in  REG_WIDTH  byte address of row 0
cfg_oa_rows  in  REG_WIDTH  rows in this job
cfg_oa_row_stride  in  REG_WIDTH  byte stride between rows
vec_valid  in  1  output row valid
vec_ready  out  1  engine can accept a row
vec_data  in  SIZE*8  lane i at bits [8i+7:8i]
write_oa_req  out  1  bus request to controller
write_oa_granted  in  1  bus grant from controller
write_done  out  1  one-cycle pulse per completed row
oa_calc_over  out  1  level; all rows written
oa_err  out  1  sticky ICB error flag
icb_cmd_valid  out  1  ICB command valid
icb_cmd_ready  in  1  ICB command ready
icb_cmd_addr  out  REG_WIDTH  byte address
icb_cmd_read  out  1  constant 0 (write only)
icb_cmd_wdata  out  BUS_WIDTH  write data
icb_cmd_wmask  out  BUS_WIDTH/8  constant all ones
icb_rsp_valid  in  1  ICB response valid
icb_rsp_ready  out  1  constant 1
icb_rsp_err  in  1  ICB response error

Behaviour:
- Reset:
  - All outputs 0, except icb_rsp_ready=1 and icb_cmd_wmask all ones.
  - State IDLE; counters and registers cleared.
  - Reset mid-operation abandons the row; no further commands are issued.
- FSM states: IDLE, WAIT_DATA, REQ, WRITE, DRAIN, DONE.
- IDLE / DONE:
  - On init_cfg_oa, latch the config, set row_addr=base, row_cnt=0, clear oa_err and oa_calc_over.
  - Next state is WAIT_DATA, or DONE if cfg_oa_rows==0.
  - With rows==0, oa_calc_over=1 on the cycle after the pulse.
  - init_cfg_oa in any other state is ignored.
- WAIT_DATA:
  - vec_ready=1 (registered, asserted while in WAIT_DATA only).
  - On vec_valid&&vec_ready, capture vec_data into the row buffer and go to REQ.
- REQ:
  - write_oa_req=1.
  - On write_oa_granted, set word_idx=0 and go to WRITE.
  - write_oa_req stays 1 through WRITE and DRAIN and drops on the cycle write_done pulses.
- WRITE:
  - icb_cmd_valid=1.
  - icb_cmd_addr = row_addr + word_idx*(BUS_WIDTH/8).
  - icb_cmd_wdata = row buffer bits [word_idx*BUS_WIDTH +: BUS_WIDTH], i.e. little-endian, lane 0 at the lowest address.
  - Address and data are held stable while valid&&!ready.
  - On handshake, word_idx++. The handshake of word WORDS-1 moves to DRAIN.
  - No command is ever issued outside WRITE.
- Responses:
  - Counted in any state via rsp_cnt (0..WORDS), so pipelined responses during WRITE are legal.
  - icb_rsp_err sets oa_err, which stays set until the next init_cfg_oa.
  - An error does not abort the row.
- DRAIN:
  - When rsp_cnt reaches WORDS (including a response arriving this cycle): pulse write_done for 1 cycle, row_cnt++, row_addr += stride, rsp_cnt=0.
  - If the new row_cnt == rows, go to DONE and set oa_calc_over=1 in the same cycle as the final write_done; otherwise go to WAIT_DATA.
- Address arithmetic is modulo 2^REG_WIDTH; wrap is not flagged.
- A response received while rsp_cnt==WORDS is a protocol violation; the count saturates.

Test Plan:
1. base=0x1000, rows=2, stride=0x40; rows bytes 0x00..0x0F then 0x10..0x1F; grant 2 cycles after req; cmd_ready=1; rsp 1 cycle after cmd -> writes 0x1000:0x03020100, 0x1004:0x07060504, 0x1008:0x0B0A0908, 0x100C:0x0F0E0D0C, then 0x1040:0x13121110 .. 0x104C:0x1F1E1D1C; two write_done pulses; oa_calc_over=1 with the second.
2. cmd_ready toggling 1-of-3 cycles -> addr/wdata unchanged while stalled; 4 handshakes per row; write_done only after the 4th response.
3. Grant withheld 10 cycles -> write_oa_req held high, icb_cmd_valid=0 throughout; writes start 1 cycle after grant.
4. rows=0 -> oa_calc_over=1 one cycle after init_cfg_oa; write_oa_req never asserted; vec_ready stays 0.
5. icb_rsp_err on the 3rd response of row 0 -> oa_err=1 from the next cycle; row completes and write_done pulses; next init_cfg_oa clears oa_err to 0.
6. Assert rst_n=0 after the 2nd handshake of a row -> all outputs return to reset values and no cmd follows; a new init plus a row writes correctly from the new base.

Source files
------------

// File: rtl/oa_write_engine.sv
// ICB write master for the output-activation end of the MMA datapath.
// Packs one int8 row into bus words and writes it once the controller grants the bus.
module oa_write_engine #(
    parameter int SIZE      = 16,
    parameter int BUS_WIDTH = 32,
    parameter int REG_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_cfg_oa,
    input  logic [REG_WIDTH-1:0]     cfg_oa_base_addr,
    input  logic [REG_WIDTH-1:0]     cfg_oa_rows,
    input  logic [REG_WIDTH-1:0]     cfg_oa_row_stride,
    input  logic                     vec_valid,
    output logic                     vec_ready,
    input  logic [SIZE*8-1:0]        vec_data,
    output logic                     write_oa_req,
    input  logic                     write_oa_granted,
    output logic                     write_done,
    output logic                     oa_calc_over,
    output logic                     oa_err,
    output logic                     icb_cmd_valid,
    input  logic                     icb_cmd_ready,
    output logic [REG_WIDTH-1:0]     icb_cmd_addr,
    output logic                     icb_cmd_read,
    output logic [BUS_WIDTH-1:0]     icb_cmd_wdata,
    output logic [BUS_WIDTH/8-1:0]   icb_cmd_wmask,
    input  logic                     icb_rsp_valid,
    output logic                     icb_rsp_ready,
    input  logic                     icb_rsp_err
);

    localparam int WORDS  = SIZE * 8 / BUS_WIDTH;
    localparam int BYTES  = BUS_WIDTH / 8;
    localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int RCNT_W = $clog2(WORDS + 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_DATA, REQ, WRITE, DRAIN, DONE
    } state_t;

    state_t                            state_q, state_d;
    logic [REG_WIDTH-1:0]              rows_q, rows_d;
    logic [REG_WIDTH-1:0]              stride_q, stride_d;
    logic [REG_WIDTH-1:0]              row_addr_q, row_addr_d;
    logic [REG_WIDTH-1:0]              row_cnt_q, row_cnt_d;
    logic [WORDS-1:0][BUS_WIDTH-1:0]   buf_q, buf_d;
    logic [WIDX_W-1:0]                 word_idx_q, word_idx_d;
    logic [RCNT_W-1:0]                 rsp_cnt_q, rsp_cnt_d;
    logic                              err_q, err_d;
    logic                              over_q, over_d;
    logic                              done_q, done_d;

    logic                              rsp_full;
    logic [REG_WIDTH-1:0]              row_cnt_inc;

    // A response landing this cycle may complete the row.
    assign rsp_full = (rsp_cnt_q == RCNT_W'(WORDS)) ||
                      ((rsp_cnt_q == RCNT_W'(WORDS - 1)) && icb_rsp_valid);
    assign row_cnt_inc = row_cnt_q + REG_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rows_q     <= '0;
            stride_q   <= '0;
            row_addr_q <= '0;
            row_cnt_q  <= '0;
            buf_q      <= '0;
            word_idx_q <= '0;
            rsp_cnt_q  <= '0;
            err_q      <= 1'b0;
            over_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            stride_q   <= stride_d;
            row_addr_q <= row_addr_d;
            row_cnt_q  <= row_cnt_d;
            buf_q      <= buf_d;
            word_idx_q <= word_idx_d;
            rsp_cnt_q  <= rsp_cnt_d;
            err_q      <= err_d;
            over_q     <= over_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        stride_d   = stride_q;
        row_addr_d = row_addr_q;
        row_cnt_d  = row_cnt_q;
        buf_d      = buf_q;
        word_idx_d = word_idx_q;
        rsp_cnt_d  = rsp_cnt_q;
        err_d      = err_q;
        over_d     = over_q;
        done_d     = 1'b0;

        // Count saturates so a stray extra response cannot wrap the counter.
        if (icb_rsp_valid && (rsp_cnt_q != RCNT_W'(WORDS)))
            rsp_cnt_d = rsp_cnt_q + 1'b1;
        if (icb_rsp_valid && icb_rsp_err)
            err_d = 1'b1;

        unique case (state_q)
            IDLE, DONE: begin
                if (init_cfg_oa) begin
                    rows_d     = cfg_oa_rows;
                    stride_d   = cfg_oa_row_stride;
                    row_addr_d = cfg_oa_base_addr;
                    row_cnt_d  = '0;
                    rsp_cnt_d  = '0;
                    err_d      = 1'b0;
                    if (cfg_oa_rows == '0) begin
                        over_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        over_d  = 1'b0;
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (vec_valid) begin
                    buf_d   = vec_data;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (write_oa_granted) begin
                    word_idx_d = '0;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (icb_cmd_ready) begin
                    word_idx_d = word_idx_q + 1'b1;
                    if (word_idx_q == WIDX_W'(WORDS - 1))
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rsp_full) begin
                    done_d     = 1'b1;
                    row_cnt_d  = row_cnt_inc;
                    row_addr_d = row_addr_q + stride_q;
                    rsp_cnt_d  = '0;
                    if (row_cnt_inc == rows_q) begin
                        over_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign vec_ready     = (state_q == WAIT_DATA);
    assign write_oa_req  = (state_q == REQ) || (state_q == WRITE) ||
                           (state_q == DRAIN);
    assign icb_cmd_valid = (state_q == WRITE);
    assign icb_cmd_addr  = row_addr_q +
                           REG_WIDTH'(word_idx_q) * REG_WIDTH'(BYTES);
    assign icb_cmd_wdata = buf_q[word_idx_q];
    assign icb_cmd_read  = 1'b0;
    assign icb_cmd_wmask = '1;
    assign icb_rsp_ready = 1'b1;
    assign write_done    = done_q;
    assign oa_calc_over  = over_q;
    assign oa_err        = err_q;

endmodule

// File: tb/tb_oa_write_engine.sv
// Bench for oa_write_engine: a bus/controller agent plus a row-to-write
// reference model built from byte lists.
module tb_oa_write_engine;

    localparam int SIZE  = 16;
    localparam int BW    = 32;
    localparam int RW    = 32;
    localparam int WORDS = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            init_cfg_oa = 1'b0;
    logic [RW-1:0]   cfg_oa_base_addr = '0;
    logic [RW-1:0]   cfg_oa_rows = '0;
    logic [RW-1:0]   cfg_oa_row_stride = '0;
    logic            vec_valid = 1'b0;
    logic            vec_ready;
    logic [127:0]    vec_data = '0;
    logic            write_oa_req;
    logic            write_oa_granted = 1'b0;
    logic            write_done;
    logic            oa_calc_over;
    logic            oa_err;
    logic            icb_cmd_valid;
    logic            icb_cmd_ready = 1'b0;
    logic [RW-1:0]   icb_cmd_addr;
    logic            icb_cmd_read;
    logic [BW-1:0]   icb_cmd_wdata;
    logic [3:0]      icb_cmd_wmask;
    logic            icb_rsp_valid = 1'b0;
    logic            icb_rsp_ready;
    logic            icb_rsp_err = 1'b0;

    oa_write_engine #(.SIZE(SIZE), .BUS_WIDTH(BW), .REG_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n), .init_cfg_oa(init_cfg_oa),
        .cfg_oa_base_addr(cfg_oa_base_addr), .cfg_oa_rows(cfg_oa_rows),
        .cfg_oa_row_stride(cfg_oa_row_stride),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
        .write_oa_req(write_oa_req), .write_oa_granted(write_oa_granted),
        .write_done(write_done), .oa_calc_over(oa_calc_over), .oa_err(oa_err),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_err(icb_rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // agent knobs
    int ready_mode = 0;
    int rsp_delay = 1;
    int grant_delay = 0;
    int err_idx = 0;

    // agent observations
    int cyc = 0;
    int rsp_idx, rsp_total, hs_cnt, done_cnt, req_cyc, last_due;
    int grant_cyc, lat, wait_at_grant, err_cyc, cmd_seen;
    int stall_viol, cmd_viol, done_rsp_viol;
    bit lat_pending, stalled;
    logic err_before, err_next;
    logic [31:0] st_addr, st_data;
    int rq[$];
    logic [63:0] wr_q[$];
    bit done_calc[$];
    logic [127:0] rows_in[$];

    // Controller grant, ICB slave with delayed responses, and protocol monitor.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rq.delete();
                stalled = 1'b0;
                lat_pending = 1'b0;
            end
            if (cyc == err_cyc + 1) err_next = oa_err;
            if (icb_cmd_valid) cmd_seen++;
            if (write_done) begin
                if (rsp_total != WORDS * (done_cnt + 1)) done_rsp_viol++;
                done_calc.push_back(oa_calc_over);
                done_cnt++;
            end
            if (icb_cmd_valid && !(write_oa_req && write_oa_granted))
                cmd_viol++;
            if (stalled && (!icb_cmd_valid || icb_cmd_addr !== st_addr ||
                            icb_cmd_wdata !== st_data))
                stall_viol++;
            if (icb_cmd_valid && lat_pending) begin
                lat = cyc - grant_cyc;
                lat_pending = 1'b0;
            end
            if (!write_oa_req || !rst_n) begin
                req_cyc = 0;
                write_oa_granted = 1'b0;
            end else begin
                req_cyc++;
                if (!write_oa_granted && req_cyc > grant_delay) begin
                    write_oa_granted = 1'b1;
                    wait_at_grant = req_cyc - 1;
                    grant_cyc = cyc;
                    lat_pending = 1'b1;
                end
            end
            icb_rsp_valid = 1'b0;
            icb_rsp_err = 1'b0;
            if (rq.size() > 0 && rq[0] <= cyc) begin
                void'(rq.pop_front());
                icb_rsp_valid = 1'b1;
                rsp_idx++;
                rsp_total++;
                if (rsp_idx == err_idx) begin
                    icb_rsp_err = 1'b1;
                    err_cyc = cyc;
                    err_before = oa_err;
                end
            end
            case (ready_mode)
                1: icb_cmd_ready = (cyc % 3 == 0);
                2: icb_cmd_ready = 1'($urandom_range(0, 1));
                default: icb_cmd_ready = 1'b1;
            endcase
            stalled = 1'b0;
            if (icb_cmd_valid && icb_cmd_ready && rst_n) begin
                wr_q.push_back({icb_cmd_addr, icb_cmd_wdata});
                hs_cnt++;
                last_due = (cyc + rsp_delay > last_due + 1) ?
                           cyc + rsp_delay : last_due + 1;
                rq.push_back(last_due);
            end else if (icb_cmd_valid) begin
                stalled = 1'b1;
                st_addr = icb_cmd_addr;
                st_data = icb_cmd_wdata;
            end
        end
    end

    task automatic clear_bk();
        rsp_idx = 0; rsp_total = 0; hs_cnt = 0; done_cnt = 0;
        last_due = 0; lat = -1; wait_at_grant = -1; err_cyc = -100;
        err_idx = 0; cmd_seen = 0; stall_viol = 0; cmd_viol = 0;
        done_rsp_viol = 0; err_before = 1'bx; err_next = 1'bx;
        wr_q.delete(); done_calc.delete(); rows_in.delete();
    endtask

    task automatic start_job(input logic [31:0] base, input logic [31:0] rows,
                             input logic [31:0] stride);
        @(negedge clk);
        clear_bk();
        cfg_oa_base_addr = base;
        cfg_oa_rows = rows;
        cfg_oa_row_stride = stride;
        init_cfg_oa = 1'b1;
        @(negedge clk);
        init_cfg_oa = 1'b0;
    endtask

    task automatic send_row(input logic [127:0] d);
        int t;
        t = 0;
        rows_in.push_back(d);
        vec_data = d;
        vec_valid = 1'b1;
        while (!vec_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!vec_ready) begin
            failures++;
            $display("FAIL send_row: vec_ready=%b after %0d cycles, need 1", vec_ready, t);
        end
        @(negedge clk);
        vec_valid = 1'b0;
    endtask

    task automatic wait_over(input string nm);
        int t;
        t = 0;
        while (!oa_calc_over && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!oa_calc_over) begin
            failures++;
            $display("FAIL %s timeout: oa_calc_over=%b, need 1", nm, oa_calc_over);
        end
        repeat (3) @(negedge clk);
    endtask

    // Reference: row r, word w goes to base + r*stride + 4w holding bytes
    // 4w..4w+3 of that row, lowest-numbered byte in the least significant lane.
    task automatic check_writes(input string nm, input logic [31:0] base,
                                input logic [31:0] stride);
        logic [63:0] e[$];
        logic [31:0] a, d;
        logic [7:0] b;
        for (int r = 0; r < rows_in.size(); r++) begin
            for (int w = 0; w < WORDS; w++) begin
                a = base + stride * 32'(r) + 32'(4 * w);
                d = '0;
                for (int k = 0; k < 4; k++) begin
                    b = rows_in[r][8*(4*w+k) +: 8];
                    d = d | (32'(b) << (8 * k));
                end
                e.push_back({a, d});
            end
        end
        checks++;
        if (wr_q.size() != e.size()) begin
            failures++;
            $display("FAIL %s count: got %0d writes, need %0d", nm, wr_q.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== e[i]) begin
                failures++;
                $display("FAIL %s write %0d: got %h:%h, need %h:%h", nm, i,
                         wr_q[i][63:32], wr_q[i][31:0], e[i][63:32], e[i][31:0]);
            end
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        logic [77:0] got, exp;
        got = {vec_ready, write_oa_req, write_done, oa_calc_over, oa_err,
               icb_cmd_valid, icb_cmd_read, icb_rsp_ready, icb_cmd_wmask,
               icb_cmd_addr, icb_cmd_wdata};
        exp = {8'b0000_0001, 4'hF, 32'h0, 32'h0};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s outputs: got %h, need %h", nm, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_basic();
        logic [127:0] r0, r1;
        for (int i = 0; i < 16; i++) begin
            r0[8*i +: 8] = 8'(i);
            r1[8*i +: 8] = 8'(i + 16);
        end
        ready_mode = 0; rsp_delay = 1; grant_delay = 2;
        start_job(32'h1000, 2, 32'h40);
        send_row(r0);
        send_row(r1);
        wait_over("basic");
        check_writes("basic", 32'h1000, 32'h40);
        checks++;
        if (done_cnt != 2) begin
            failures++;
            $display("FAIL basic done_cnt: got %0d, need 2", done_cnt);
        end
        checks++;
        if (done_calc.size() != 2 || done_calc[0] != 1'b0 || done_calc[1] != 1'b1) begin
            failures++;
            $display("FAIL basic calc_over_at_done: got size %0d, need {0,1}", done_calc.size());
        end
        checks++;
        if (done_rsp_viol != 0 || cmd_viol != 0) begin
            failures++;
            $display("FAIL basic protocol: got rsp_viol=%0d cmd_viol=%0d, need 0",
                     done_rsp_viol, cmd_viol);
        end
    endtask

    task automatic test_stall();
        ready_mode = 1; rsp_delay = 2; grant_delay = 1;
        start_job(32'h8000, 2, 32'h100);
        send_row({$urandom, $urandom, $urandom, $urandom});
        send_row({$urandom, $urandom, $urandom, $urandom});
        wait_over("stall");
        check_writes("stall", 32'h8000, 32'h100);
        checks++;
        if (stall_viol != 0) begin
            failures++;
            $display("FAIL stall hold: got %0d changes while stalled, need 0", stall_viol);
        end
        checks++;
        if (hs_cnt != 2 * WORDS) begin
            failures++;
            $display("FAIL stall handshakes: got %0d, need %0d", hs_cnt, 2 * WORDS);
        end
        checks++;
        if (done_rsp_viol != 0 || done_cnt != 2) begin
            failures++;
            $display("FAIL stall done_timing: got viol=%0d done=%0d, need 0 and 2",
                     done_rsp_viol, done_cnt);
        end
    endtask

    task automatic test_grant_hold();
        ready_mode = 0; rsp_delay = 1; grant_delay = 10;
        start_job(32'h4000, 1, 32'h0);
        send_row({$urandom, $urandom, $urandom, $urandom});
        wait_over("grant");
        check_writes("grant", 32'h4000, 32'h0);
        checks++;
        if (wait_at_grant != 10) begin
            failures++;
            $display("FAIL grant req_held: got %0d cycles, need 10", wait_at_grant);
        end
        checks++;
        if (cmd_viol != 0) begin
            failures++;
            $display("FAIL grant cmd_before_grant: got %0d, need 0", cmd_viol);
        end
        checks++;
        if (lat != 1) begin
            failures++;
            $display("FAIL grant latency: got %0d, need 1", lat);
        end
    endtask

    task automatic test_zero_rows();
        int bad;
        bad = 0;
        grant_delay = 0;
        start_job(32'h5000, 0, 32'h10);
        checks++;
        if (oa_calc_over !== 1'b1) begin
            failures++;
            $display("FAIL zero_rows calc_over: got %b, need 1", oa_calc_over);
        end
        for (int i = 0; i < 10; i++) begin
            if (vec_ready || write_oa_req) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL zero_rows idle: got %0d active cycles, need 0", bad);
        end
    endtask

    task automatic test_error();
        ready_mode = 0; rsp_delay = 1; grant_delay = 0;
        start_job(32'h6000, 1, 32'h0);
        err_idx = 3;
        send_row({$urandom, $urandom, $urandom, $urandom});
        wait_over("error");
        check_writes("error", 32'h6000, 32'h0);
        checks++;
        if (err_before !== 1'b0 || err_next !== 1'b1) begin
            failures++;
            $display("FAIL error timing: got before=%b next=%b, need 0 and 1",
                     err_before, err_next);
        end
        checks++;
        if (oa_err !== 1'b1 || done_cnt != 1) begin
            failures++;
            $display("FAIL error sticky: got oa_err=%b done=%0d, need 1 and 1",
                     oa_err, done_cnt);
        end
        start_job(32'h6000, 0, 32'h0);
        checks++;
        if (oa_err !== 1'b0) begin
            failures++;
            $display("FAIL error clear: got %b, need 0", oa_err);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        ready_mode = 0; rsp_delay = 1; grant_delay = 1;
        start_job(32'h2000, 1, 32'h0);
        send_row({$urandom, $urandom, $urandom, $urandom});
        t = 0;
        while (hs_cnt < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmd_seen = 0;
        repeat (8) @(negedge clk);
        checks++;
        if (cmd_seen != 0 || oa_calc_over !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid quiet: got cmds=%0d over=%b, need 0 and 0",
                     cmd_seen, oa_calc_over);
        end
        start_job(32'h3000, 1, 32'h0);
        send_row({$urandom, $urandom, $urandom, $urandom});
        wait_over("reset_mid_new");
        check_writes("reset_mid_new", 32'h3000, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] base, stride, rows;
        for (int j = 0; j < 4; j++) begin
            base = (j == 0) ? 32'hFFFF_FFF8 : $urandom;
            stride = $urandom;
            rows = 32'($urandom_range(1, 3));
            ready_mode = 2;
            rsp_delay = $urandom_range(1, 3);
            grant_delay = $urandom_range(0, 3);
            start_job(base, rows, stride);
            for (int r = 0; r < int'(rows); r++)
                send_row({$urandom, $urandom, $urandom, $urandom});
            wait_over("random");
            check_writes("random", base, stride);
            checks++;
            if (done_cnt != int'(rows) || done_rsp_viol != 0 ||
                stall_viol != 0 || cmd_viol != 0) begin
                failures++;
                $display("FAIL random job%0d: got done=%0d rv=%0d sv=%0d cv=%0d, need %0d/0/0/0",
                         j, done_cnt, done_rsp_viol, stall_viol, cmd_viol, rows);
            end
        end
    endtask

    initial begin
        clear_bk();
        test_reset();
        test_basic();
        test_stall();
        test_grant_hold();
        test_zero_rows();
        test_error();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
